// File: rtl/clock_mode_controller.sv
// -----------------------------------------------------------------------------
// clock_mode_controller
//
// Purpose:
//   Switches the digital-clock time counter between normal RUN and the two
//   manual time-setting modes. The three front-panel buttons are synchronized
//   and debounced here. The block gates the one-second tick, issues
//   single-cycle hour/minute increment strobes, and drives the blink masks
//   for the field being edited.
//
// Ports:
//   clk                 in   system clock
//   reset               in   asynchronous, active-high reset
//   one_second_pulse    in   single-cycle tick from the clock divider
//   mode_button         in   raw mode button (asynchronous)
//   set_hours_button    in   raw set-hours button (asynchronous)
//   set_minutes_button  in   raw set-minutes button (asynchronous)
//   tick_out            out  gated one-second tick (RUN only, 1-cycle latency)
//   inc_hours           out  single-cycle hour increment strobe
//   inc_minutes         out  single-cycle minute increment strobe
//   clear_seconds       out  single-cycle strobe on every entry into RUN
//   blank_hours         out  blanks hours digits while editing hours
//   blank_minutes       out  blanks minutes digits while editing minutes
//   mode                out  0 RUN, 1 SET_HOURS, 2 SET_MINUTES
//
// Optional feature:
//   CLOCK_MODE_AUTO_REPEAT_EN - when defined, holding the active field's set
//   button produces extra strobes. The first extra strobe comes after
//   REPEAT_DELAY cycles, and further strobes follow every REPEAT_PERIOD cycles.
// -----------------------------------------------------------------------------
module clock_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int TIMEOUT_SEC     = 30,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second_pulse,
    input  logic       mode_button,
    input  logic       set_hours_button,
    input  logic       set_minutes_button,
    output logic       tick_out,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       clear_seconds,
    output logic       blank_hours,
    output logic       blank_minutes,
    output logic [1:0] mode
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BLW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TOW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_SEC - 1);

    localparam int BTN_MODE = 0;
    localparam int BTN_HRS  = 1;
    localparam int BTN_MIN  = 2;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2
    } state_e;

    state_e           mode_q, state_d;
    logic [TOW-1:0]   tout_q, tout_d;
    logic [BLW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             tick_q, inc_hours_q, inc_minutes_q, clear_seconds_q;
    logic             blank_hours_q, blank_minutes_q;
    logic             inc_hours_d, inc_minutes_d, clear_seconds_d;

    logic [2:0]       raw_s;
    logic [2:0]       sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [DBW-1:0]   deb_cnt_q [3];
    logic [2:0]       press_s;
    logic             field_press_s;
    logic             strobe_s;
    logic             rep_fire_s;

    assign raw_s   = {set_minutes_button, set_hours_button, mode_button};
    assign press_s = deb_q & ~deb_prev_q;

    // Two-flop synchronizers and per-button debounce. The counter only runs
    // while the synchronized level disagrees with the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= {DBW{1'b0}};
            end
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= {DBW{1'b0}};
                end else if (deb_cnt_q[i] == DB_LAST) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= {DBW{1'b0}};
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // Select the set button that belongs to the field currently being edited.
    always_comb begin
        field_press_s = 1'b0;
        case (mode_q)
            ST_SET_HOURS:   field_press_s = press_s[BTN_HRS];
            ST_SET_MINUTES: field_press_s = press_s[BTN_MIN];
            default:        field_press_s = 1'b0;
        endcase
    end

`ifdef CLOCK_MODE_AUTO_REPEAT_EN
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW   = (RPMAX > 1) ? $clog2(RPMAX) : 1;
    localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);

    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
    logic           rep_armed_q, rep_armed_d;
    logic           rep_run_s;

    assign rep_run_s = ((mode_q == ST_SET_HOURS) & deb_q[BTN_HRS]) |
                       ((mode_q == ST_SET_MINUTES) & deb_q[BTN_MIN]);

    // Auto-repeat timing. The first extra strobe waits the long delay, and
    // later strobes use the shorter period. A fresh press, a mode press, a
    // release or a state change restarts the sequence.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire_s  = 1'b0;
        if (!rep_run_s || field_press_s || press_s[BTN_MODE]) begin
            rep_cnt_d   = {RPW{1'b0}};
            rep_armed_d = 1'b0;
        end else if (!rep_armed_q && (rep_cnt_q == RD_LAST)) begin
            rep_fire_s  = 1'b1;
            rep_cnt_d   = {RPW{1'b0}};
            rep_armed_d = 1'b1;
        end else if (rep_armed_q && (rep_cnt_q == RP_LAST)) begin
            rep_fire_s  = 1'b1;
            rep_cnt_d   = {RPW{1'b0}};
        end else begin
            rep_cnt_d   = rep_cnt_q + RPW'(1);
        end
    end

    // Auto-repeat state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= {RPW{1'b0}};
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // A mode press always wins over an increment in the same cycle.
    assign strobe_s = (field_press_s | rep_fire_s) & ~press_s[BTN_MODE] & (mode_q != ST_RUN);

    // Mode sequencing, inactivity timeout and strobe generation.
    always_comb begin
        state_d         = mode_q;
        tout_d          = tout_q;
        clear_seconds_d = 1'b0;
        inc_hours_d     = 1'b0;
        inc_minutes_d   = 1'b0;
        case (mode_q)
            ST_RUN: begin
                tout_d = {TOW{1'b0}};
                if (press_s[BTN_MODE]) begin
                    state_d = ST_SET_HOURS;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_HOURS, ST_SET_MINUTES: begin
                if (press_s[BTN_MODE]) begin
                    state_d         = (mode_q == ST_SET_HOURS) ? ST_SET_MINUTES : ST_RUN;
                    clear_seconds_d = (mode_q == ST_SET_MINUTES);
                    tout_d          = {TOW{1'b0}};
                end else if (strobe_s) begin
                    // An accepted press beats a coinciding timeout.
                    tout_d        = {TOW{1'b0}};
                    inc_hours_d   = (mode_q == ST_SET_HOURS);
                    inc_minutes_d = (mode_q == ST_SET_MINUTES);
                end else if (one_second_pulse) begin
                    if (tout_q == TO_LAST) begin
                        state_d         = ST_RUN;
                        clear_seconds_d = 1'b1;
                        tout_d          = {TOW{1'b0}};
                    end else begin
                        tout_d = tout_q + TOW'(1);
                    end
                end else begin
                    tout_d = tout_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                tout_d  = {TOW{1'b0}};
            end
        endcase
    end

    // Blink phase. It restarts visible on state entry and after each strobe.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if ((state_d == ST_RUN) || (state_d != mode_q) || inc_hours_d || inc_minutes_d) begin
            blink_cnt_d = {BLW{1'b0}};
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = {BLW{1'b0}};
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLW'(1);
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q          <= ST_RUN;
            tout_q          <= {TOW{1'b0}};
            blink_cnt_q     <= {BLW{1'b0}};
            phase_q         <= 1'b0;
            tick_q          <= 1'b0;
            inc_hours_q     <= 1'b0;
            inc_minutes_q   <= 1'b0;
            clear_seconds_q <= 1'b0;
            blank_hours_q   <= 1'b0;
            blank_minutes_q <= 1'b0;
        end else begin
            mode_q          <= state_d;
            tout_q          <= tout_d;
            blink_cnt_q     <= blink_cnt_d;
            phase_q         <= phase_d;
            tick_q          <= (mode_q == ST_RUN) & one_second_pulse;
            inc_hours_q     <= inc_hours_d;
            inc_minutes_q   <= inc_minutes_d;
            clear_seconds_q <= clear_seconds_d;
            blank_hours_q   <= (state_d == ST_SET_HOURS) & phase_d;
            blank_minutes_q <= (state_d == ST_SET_MINUTES) & phase_d;
        end
    end

    assign tick_out      = tick_q;
    assign inc_hours     = inc_hours_q;
    assign inc_minutes   = inc_minutes_q;
    assign clear_seconds = clear_seconds_q;
    assign blank_hours   = blank_hours_q;
    assign blank_minutes = blank_minutes_q;
    assign mode          = mode_q;

endmodule
